// File: rtl/ftdi_pkg.sv
// ftdi_pkg: shared types and parameter defaults for the FTDI scheduler.
//   dir_state_t : FTDI direction FSM states (idle / read / write)
//   arb_state_t : write-queue packet arbiter states (idle / source 0 / source 1)
package ftdi_pkg;

  localparam int unsigned SLICE_DEF   = 64;   // max consecutive cycles per direction
  localparam int unsigned PKT_MAX_DEF = 256;  // max bytes per packet before forced release

  typedef enum logic [1:0] {
    DIR_IDLE = 2'd0,
    DIR_RD   = 2'd1,
    DIR_WR   = 2'd2
  } dir_state_t;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_S0   = 2'd1,
    ARB_S1   = 2'd2
  } arb_state_t;

endpackage

// File: rtl/ftdi_sched_if.sv
// ftdi_sched_if: byte-stream sources and write-queue push bundle.
//   s0_* : source 0 (laser RX) valid/data/last in, ready out
//   s1_* : source 1 (status/ack) valid/data/last in, ready out
//   wrreq/data_wr : push into the FTDI_Interface write queue
// master = source/queue side, slave = scheduler side.
interface ftdi_sched_if;

  logic       s0_valid;
  logic [7:0] s0_data;
  logic       s0_last;
  logic       s0_ready;

  logic       s1_valid;
  logic [7:0] s1_data;
  logic       s1_last;
  logic       s1_ready;

  logic       wrreq;
  logic [7:0] data_wr;

  modport master (
    output s0_valid, s0_data, s0_last,
    input  s0_ready,
    output s1_valid, s1_data, s1_last,
    input  s1_ready,
    input  wrreq, data_wr
  );

  modport slave (
    input  s0_valid, s0_data, s0_last,
    output s0_ready,
    input  s1_valid, s1_data, s1_last,
    output s1_ready,
    output wrreq, data_wr
  );

endinterface

// File: rtl/pkt_arb.sv
// pkt_arb: round-robin packet arbiter for the FTDI write queue.
//   clock, reset_n (async active-low), clear (sync return to idle)
//   wrq_full  : write queue full, stalls the granted source
//   s0_*/s1_* : source byte streams (valid/data/last in, ready out)
//   wrreq/data_wr : write-queue push, combinational from the granted source
//   grant     : one-hot owner (00 = none)
//   force_rel : one-cycle pulse when a packet is cut at PKT_MAX bytes
module pkt_arb
  import ftdi_pkg::*;
#(
  parameter int unsigned PKT_MAX = PKT_MAX_DEF
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       clear,
  input  logic       wrq_full,
  input  logic       s0_valid,
  input  logic [7:0] s0_data,
  input  logic       s0_last,
  output logic       s0_ready,
  input  logic       s1_valid,
  input  logic [7:0] s1_data,
  input  logic       s1_last,
  output logic       s1_ready,
  output logic       wrreq,
  output logic [7:0] data_wr,
  output logic [1:0] grant,
  output logic       force_rel
);

  // Count of the PKT_MAX-th byte; PKT_MAX-1 always fits 10 bits.
  localparam logic [9:0] CNT_LAST = 10'(PKT_MAX - 1);

  arb_state_t st_q, st_d;
  logic       rr_q, rr_d;
  logic [9:0] cnt_q, cnt_d;

  logic       cur_valid;
  logic [7:0] cur_data;
  logic       cur_last;
  logic       accept;

  always_comb begin
    st_d      = st_q;
    rr_d      = rr_q;
    cnt_d     = cnt_q;
    s0_ready  = 1'b0;
    s1_ready  = 1'b0;
    cur_valid = 1'b0;
    cur_data  = '0;
    cur_last  = 1'b0;
    accept    = 1'b0;
    force_rel = 1'b0;

    case (st_q)
      ARB_IDLE: begin
        if (!rr_q) begin
          if (s0_valid)      st_d = ARB_S0;
          else if (s1_valid) st_d = ARB_S1;
        end else begin
          if (s1_valid)      st_d = ARB_S1;
          else if (s0_valid) st_d = ARB_S0;
        end
      end
      ARB_S0: begin
        s0_ready  = !wrq_full;
        cur_valid = s0_valid;
        cur_data  = s0_data;
        cur_last  = s0_last;
      end
      ARB_S1: begin
        s1_ready  = !wrq_full;
        cur_valid = s1_valid;
        cur_data  = s1_data;
        cur_last  = s1_last;
      end
      default: st_d = ARB_IDLE;
    endcase

    // Shared acceptance path for whichever source owns the queue.
    if (st_q == ARB_S0 || st_q == ARB_S1) begin
      accept = cur_valid && !wrq_full;
      if (accept) begin
        if (cur_last || cnt_q == CNT_LAST) begin
          st_d      = ARB_IDLE;
          rr_d      = (st_q == ARB_S0);
          cnt_d     = '0;
          force_rel = !cur_last;
        end else begin
          cnt_d = cnt_q + 10'd1;
        end
      end
    end

    if (clear) begin
      st_d      = ARB_IDLE;
      rr_d      = 1'b0;
      cnt_d     = '0;
      force_rel = 1'b0;
    end
  end

  assign wrreq   = accept;
  assign data_wr = cur_data;
  assign grant   = {st_q == ARB_S1, st_q == ARB_S0};

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      st_q  <= ARB_IDLE;
      rr_q  <= 1'b0;
      cnt_q <= '0;
    end else begin
      st_q  <= st_d;
      rr_q  <= rr_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/ftdi_sched.sv
// ftdi_sched: FTDI direction scheduler plus write-queue packet arbiter.
//   clock, reset_n (async active-low), clear (sync return to idle)
//   rxf, txe       : FTDI status, active-low (data available / space available)
//   rdq_full, wrq_full, wrq_empty : FTDI_Interface queue flags
//   rd_en, wr_en   : direction enables, mutually exclusive
//   grant          : one-hot write-queue owner (00 = none)
//   err_len        : sticky, set when a packet is cut at PKT_MAX bytes
//   src            : source streams and write-queue push (slave modport)
module ftdi_sched
  import ftdi_pkg::*;
#(
  parameter int unsigned SLICE   = SLICE_DEF,
  parameter int unsigned PKT_MAX = PKT_MAX_DEF
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         clear,
  input  logic         rxf,
  input  logic         txe,
  input  logic         rdq_full,
  input  logic         wrq_full,
  input  logic         wrq_empty,
  output logic         rd_en,
  output logic         wr_en,
  output logic [1:0]   grant,
  output logic         err_len,
  ftdi_sched_if.slave  src
);

  localparam logic [9:0] SLICE_LD = 10'(SLICE - 1);

  dir_state_t dir_q, dir_d;
  logic [9:0] slice_q, slice_d;
  logic       err_len_q, err_len_d;

  logic rd_pend;
  logic wr_pend;
  logic force_rel;

  assign rd_pend = !rxf && !rdq_full;
  assign wr_pend = !txe && !wrq_empty;

  always_comb begin
    dir_d   = dir_q;
    slice_d = slice_q;

    case (dir_q)
      DIR_IDLE: begin
        if (rd_pend) begin
          dir_d   = DIR_RD;
          slice_d = SLICE_LD;
        end else if (wr_pend) begin
          dir_d   = DIR_WR;
          slice_d = SLICE_LD;
        end
      end
      DIR_RD: begin
        if (!rd_pend || slice_q == '0) begin
          if (wr_pend) begin
            dir_d   = DIR_WR;
            slice_d = SLICE_LD;
          end else if (rd_pend) begin
            slice_d = SLICE_LD;
          end else begin
            dir_d   = DIR_IDLE;
            slice_d = '0;
          end
        end else begin
          slice_d = slice_q - 10'd1;
        end
      end
      DIR_WR: begin
        if (!wr_pend || slice_q == '0) begin
          if (rd_pend) begin
            dir_d   = DIR_RD;
            slice_d = SLICE_LD;
          end else if (wr_pend) begin
            slice_d = SLICE_LD;
          end else begin
            dir_d   = DIR_IDLE;
            slice_d = '0;
          end
        end else begin
          slice_d = slice_q - 10'd1;
        end
      end
      default: begin
        dir_d   = DIR_IDLE;
        slice_d = '0;
      end
    endcase

    err_len_d = err_len_q | force_rel;

    if (clear) begin
      dir_d     = DIR_IDLE;
      slice_d   = '0;
      err_len_d = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      dir_q     <= DIR_IDLE;
      slice_q   <= '0;
      err_len_q <= 1'b0;
    end else begin
      dir_q     <= dir_d;
      slice_q   <= slice_d;
      err_len_q <= err_len_d;
    end
  end

  assign rd_en   = (dir_q == DIR_RD);
  assign wr_en   = (dir_q == DIR_WR);
  assign err_len = err_len_q;

  pkt_arb #(
    .PKT_MAX (PKT_MAX)
  ) u_pkt_arb (
    .clock     (clock),
    .reset_n   (reset_n),
    .clear     (clear),
    .wrq_full  (wrq_full),
    .s0_valid  (src.s0_valid),
    .s0_data   (src.s0_data),
    .s0_last   (src.s0_last),
    .s0_ready  (src.s0_ready),
    .s1_valid  (src.s1_valid),
    .s1_data   (src.s1_data),
    .s1_last   (src.s1_last),
    .s1_ready  (src.s1_ready),
    .wrreq     (src.wrreq),
    .data_wr   (src.data_wr),
    .grant     (grant),
    .force_rel (force_rel)
  );

endmodule
